// File: rtl/pattern_fetch_ctrl_pkg.sv
// Shared types for the pattern fetch controller: FSM states and a log2 helper
// used to size tag fields.
package pattern_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   function automatic int log2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pattern_reorder_buf.sv
// Reorder slots for tagged read responses: one write port indexed by tag, one
// read port at the in-order head, and a flag for writes to an already-filled slot.
module pattern_reorder_buf #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_COUNT  = 4,
   parameter int TAG_WIDTH  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_en_i,
   input  logic [TAG_WIDTH-1:0]  wr_tag_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  wr_dup_o,
   input  logic [TAG_WIDTH-1:0]  head_i,
   input  logic                  head_pop_i,
   output logic                  head_valid_o,
   output logic [DATA_WIDTH-1:0] head_data_o
);

   logic [TAG_COUNT-1:0]                 valid_q, valid_d;
   logic [TAG_COUNT-1:0][DATA_WIDTH-1:0] slot_q, slot_d;

   assign wr_dup_o     = wr_en_i & valid_q[wr_tag_i];
   assign head_valid_o = valid_q[head_i];
   assign head_data_o  = slot_q[head_i];

   // A filled slot is never overwritten, so the head word stays stable under backpressure.
   always_comb begin
      valid_d = valid_q;
      slot_d  = slot_q;
      if (head_pop_i) valid_d[head_i] = 1'b0;
      if (wr_en_i && !valid_q[wr_tag_i]) begin
         valid_d[wr_tag_i] = 1'b1;
         slot_d[wr_tag_i]  = wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) valid_q <= '0;
      else       valid_q <= valid_d;
      slot_q <= slot_d;
   end

endmodule

// File: rtl/pattern_fetch_ctrl.sv
// Tagged in-order memory stream fetcher for the pattern decoder.
// Optional PATTERN_FETCH_STATS_EN adds request/stall statistics outputs.
module pattern_fetch_ctrl
   import pattern_fetch_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 48,
   parameter int DATA_WIDTH = 64,
   parameter int TAG_COUNT  = 4,
   parameter int TAG_WIDTH  = log2(TAG_COUNT),
   parameter int LEN_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] start_addr_i,
   input  logic [LEN_WIDTH-1:0]  start_len_i,
   output logic                  req_o,
   input  logic                  req_stall_i,
   output logic [TAG_WIDTH-1:0]  req_tag_o,
   output logic [ADDR_WIDTH-1:0] req_addr_o,
   input  logic                  push_i,
   input  logic [TAG_WIDTH-1:0]  push_tag_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
`ifdef PATTERN_FETCH_STATS_EN
   ,
   output logic [LEN_WIDTH-1:0]  stat_reqs_o,
   output logic [LEN_WIDTH-1:0]  stat_stall_o
`endif
);

   localparam int STRIDE = DATA_WIDTH / 8;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [LEN_WIDTH-1:0]  consumed_q, consumed_d;
   logic                  err_q;

   logic [LEN_WIDTH-1:0]  window;
   logic                  full, pending, consume, outstanding, dup;
   logic [TAG_WIDTH-1:0]  head, push_off;

   assign head     = consumed_q[TAG_WIDTH-1:0];
   assign window   = issued_q - consumed_q;
   assign full     = window >= LEN_WIDTH'(TAG_COUNT);
   assign pending  = issued_q != len_q;
   assign req_o    = (state_q == ST_RUN) && pending && !req_stall_i && !full;
   assign req_tag_o  = issued_q[TAG_WIDTH-1:0];
   assign req_addr_o = addr_q;

   // A tag is live when its distance from the head is inside the issued window.
   assign push_off    = push_tag_i - head;
   assign outstanding = LEN_WIDTH'(push_off) < window;
   assign consume     = out_valid_o && out_ready_i;

   pattern_reorder_buf #(
      .DATA_WIDTH(DATA_WIDTH),
      .TAG_COUNT (TAG_COUNT),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_rob (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_en_i     (push_i && outstanding),
      .wr_tag_i    (push_tag_i),
      .wr_data_i   (data_i),
      .wr_dup_o    (dup),
      .head_i      (head),
      .head_pop_i  (consume),
      .head_valid_o(out_valid_o),
      .head_data_o (out_data_o)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      issued_d   = issued_q;
      consumed_d = consumed_q;
      case (state_q)
         ST_IDLE: if (start_i) begin
            addr_d     = start_addr_i;
            len_d      = start_len_i;
            issued_d   = '0;
            consumed_d = '0;
            state_d    = (start_len_i == '0) ? ST_FIN : ST_RUN;
         end
         ST_RUN:   if (!pending) state_d = ST_DRAIN;
         ST_DRAIN: if (consumed_q == len_q) state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (req_o) begin
         issued_d = issued_q + LEN_WIDTH'(1);
         addr_d   = addr_q + ADDR_WIDTH'(STRIDE);
      end
      if (consume) consumed_d = consumed_q + LEN_WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         consumed_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         consumed_q <= consumed_d;
         if (push_i && (!outstanding || dup)) err_q <= 1'b1;
      end
   end

   assign busy_o = state_q != ST_IDLE;
   assign done_o = state_q == ST_FIN;
   assign err_o  = err_q;

`ifdef PATTERN_FETCH_STATS_EN
   logic [LEN_WIDTH-1:0] stat_reqs_q, stat_stall_q;
   logic                 blocked;

   assign blocked = (state_q == ST_RUN) && pending && (req_stall_i || full);

   always_ff @(posedge clk_i) begin
      if (rst_i || (state_q == ST_IDLE && start_i)) begin
         stat_reqs_q  <= '0;
         stat_stall_q <= '0;
      end else begin
         if (req_o && !(&stat_reqs_q))    stat_reqs_q  <= stat_reqs_q + LEN_WIDTH'(1);
         if (blocked && !(&stat_stall_q)) stat_stall_q <= stat_stall_q + LEN_WIDTH'(1);
      end
   end

   assign stat_reqs_o  = stat_reqs_q;
   assign stat_stall_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_pattern_fetch_ctrl.sv
// Directed bench for pattern_fetch_ctrl: ordering, reorder, window, backpressure,
// zero-length streams, error flag and mid-stream reset.
module tb_pattern_fetch_ctrl;
   localparam int AW = 48, DW = 64, TW = 2, LW = 32;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, req_stall = 1'b0;
   logic          push = 1'b0, out_ready = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [LW-1:0] start_len = '0;
   logic [TW-1:0] push_tag = '0;
   logic [DW-1:0] data = '0;
   logic          req, out_valid, busy, done, err;
   logic [TW-1:0] req_tag;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] out_data;

   int tests = 0, fails = 0, done_cnt = 0;
   logic [TW-1:0] tagq[$];
   logic [AW-1:0] addrq[$];
   logic [DW-1:0] outq[$];

   always #5 clk = ~clk;

   pattern_fetch_ctrl dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .start_addr_i(start_addr),
      .start_len_i(start_len), .req_o(req), .req_stall_i(req_stall),
      .req_tag_o(req_tag), .req_addr_o(req_addr), .push_i(push),
      .push_tag_i(push_tag), .data_i(data), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy),
      .done_o(done), .err_o(err)
   );

   // Inputs only change 2 time units after a rising edge, so negedge values
   // are exactly what the next edge will act on.
   always @(negedge clk) begin
      if (req) begin
         tagq.push_back(req_tag);
         addrq.push_back(req_addr);
      end
      if (out_valid && out_ready) outq.push_back(out_data);
      if (done) done_cnt++;
   end

   function automatic logic [DW-1:0] dv(input int t, input int i);
      return {32'(t), 32'(i)};
   endfunction

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clr();
      tagq.delete(); addrq.delete(); outq.delete(); done_cnt = 0;
   endtask

   task automatic go(input logic [AW-1:0] a, input logic [LW-1:0] l);
      start_addr = a; start_len = l; start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic resp(input logic [TW-1:0] t, input logic [DW-1:0] d);
      push = 1'b1; push_tag = t; data = d;
      cyc();
      push = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && done_cnt == 0; i++) cyc();
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1; cyc(3); rst = 1'b0; #1;
      tests++; if ({req, out_valid, busy, done, err} !== 5'b0) begin
         fails++; $display("FAIL reset outputs: got %b want 00000", {req, out_valid, busy, done, err});
      end
   endtask

   task automatic test_in_order();
      clr(); out_ready = 1'b1; req_stall = 1'b1;
      go(48'h1000, 3); #1;
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL stall_blocks_req: got %b want 0", req); end
      cyc(); req_stall = 1'b0; cyc(4);
      tests++; if (tagq.size() != 3) begin fails++; $display("FAIL inorder req_count: got %0d want 3", tagq.size()); end
      for (int i = 0; i < 3; i++) begin
         tests++; if (tagq[i] !== TW'(i) || addrq[i] !== 48'h1000 + AW'(8 * i)) begin
            fails++; $display("FAIL inorder req%0d: got tag %0d addr %h want tag %0d addr %h",
                              i, tagq[i], addrq[i], i, 48'h1000 + AW'(8 * i));
         end
      end
      for (int i = 0; i < 3; i++) resp(TW'(i), dv(1, i));
      wait_done();
      for (int i = 0; i < 3; i++) begin
         tests++; if (outq[i] !== dv(1, i)) begin fails++; $display("FAIL inorder out%0d: got %h want %h", i, outq[i], dv(1, i)); end
      end
      tests++; if (done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
         fails++; $display("FAIL inorder done: got done %0d busy %b err %b want 1 0 0", done_cnt, busy, err);
      end
   endtask

   task automatic test_reorder();
      clr(); out_ready = 1'b0;
      go(48'h2000, 4); cyc(5);
      tests++; if (tagq.size() != 4) begin fails++; $display("FAIL reorder req_count: got %0d want 4", tagq.size()); end
      resp(2'd3, dv(2, 3)); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reorder hold_t3: got %b want 0", out_valid); end
      resp(2'd1, dv(2, 1)); #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reorder hold_t1: got %b want 0", out_valid); end
      resp(2'd0, dv(2, 0)); #1;
      tests++; if (out_valid !== 1'b1 || out_data !== dv(2, 0)) begin
         fails++; $display("FAIL reorder head: got %b %h want 1 %h", out_valid, out_data, dv(2, 0));
      end
      resp(2'd2, dv(2, 2));
      out_ready = 1'b1;
      wait_done();
      tests++; if (outq.size() != 4) begin fails++; $display("FAIL reorder out_count: got %0d want 4", outq.size()); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (outq[i] !== dv(2, i)) begin fails++; $display("FAIL reorder out%0d: got %h want %h", i, outq[i], dv(2, i)); end
      end
   endtask

   task automatic test_window();
      clr(); out_ready = 1'b1;
      go(48'h4000, 8); cyc(6);
      tests++; if (tagq.size() != 4 || req !== 1'b0) begin
         fails++; $display("FAIL window full: got %0d reqs req=%b want 4 reqs req=0", tagq.size(), req);
      end
      resp(2'd0, dv(3, 0)); #1;
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL window no_bypass: got %b want 0", req); end
      cyc(); #1;
      tests++; if (req !== 1'b1 || req_tag !== 2'd0 || req_addr !== 48'h4020) begin
         fails++; $display("FAIL window refill: got req %b tag %0d addr %h want 1 0 4020", req, req_tag, req_addr);
      end
      cyc(3);
      tests++; if (tagq.size() != 5 || req !== 1'b0) begin
         fails++; $display("FAIL window one_more: got %0d reqs req=%b want 5 reqs req=0", tagq.size(), req);
      end
      rst = 1'b1; cyc(); rst = 1'b0;
   endtask

   task automatic test_backpressure();
      clr(); out_ready = 1'b0;
      go(48'h5000, 6); cyc(6);
      for (int i = 0; i < 4; i++) resp(TW'(i), dv(4, i));
      for (int i = 0; i < 10; i++) begin
         cyc(); #1;
         tests++; if (out_valid !== 1'b1 || out_data !== dv(4, 0)) begin
            fails++; $display("FAIL bp_hold c%0d: got %b %h want 1 %h", i, out_valid, out_data, dv(4, 0));
         end
      end
      tests++; if (tagq.size() != 4) begin fails++; $display("FAIL bp_no_alloc: got %0d reqs want 4", tagq.size()); end
      out_ready = 1'b1; cyc(6);
      resp(2'd0, dv(4, 4)); resp(2'd1, dv(4, 5));
      wait_done();
      tests++; if (tagq.size() != 6 || tagq[4] !== 2'd0 || addrq[5] !== 48'h5028) begin
         fails++; $display("FAIL bp_reqs: got %0d reqs tag4 %0d addr5 %h want 6 0 5028", tagq.size(), tagq[4], addrq[5]);
      end
      for (int i = 0; i < 6; i++) begin
         tests++; if (outq[i] !== dv(4, i)) begin fails++; $display("FAIL bp_out%0d: got %h want %h", i, outq[i], dv(4, i)); end
      end
      tests++; if (done_cnt != 1 || err !== 1'b0) begin fails++; $display("FAIL bp_done: got %0d err %b want 1 0", done_cnt, err); end
   endtask

   task automatic test_zero_len();
      clr();
      go(48'h0, 0); #1;
      tests++; if (done !== 1'b1 || busy !== 1'b1 || req !== 1'b0) begin
         fails++; $display("FAIL zero_len pulse: got done %b busy %b req %b want 1 1 0", done, busy, req);
      end
      cyc(); #1;
      tests++; if (done !== 1'b0 || busy !== 1'b0 || tagq.size() != 0) begin
         fails++; $display("FAIL zero_len end: got done %b busy %b reqs %0d want 0 0 0", done, busy, tagq.size());
      end
      resp(2'd2, dv(5, 0)); #1;
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL idle_push err: got %b want 1", err); end
      cyc(3);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err); end
   endtask

   task automatic test_mid_reset();
      clr(); out_ready = 1'b0;
      go(48'h6000, 2); cyc(4);
      tests++; if (busy !== 1'b1 || tagq.size() != 2) begin
         fails++; $display("FAIL drain_setup: got busy %b reqs %0d want 1 2", busy, tagq.size());
      end
      rst = 1'b1; cyc(); rst = 1'b0; #1;
      tests++; if ({req, out_valid, busy, done, err} !== 5'b0) begin
         fails++; $display("FAIL mid_reset outputs: got %b want 00000", {req, out_valid, busy, done, err});
      end
      clr();
      go(48'h7000, 1); cyc(2);
      tests++; if (tagq.size() != 1 || addrq[0] !== 48'h7000) begin
         fails++; $display("FAIL restart_req: got %0d reqs addr %h want 1 7000", tagq.size(), addrq[0]);
      end
      resp(2'd0, dv(6, 0)); resp(2'd0, dv(6, 9)); #1;
      tests++; if (err !== 1'b1 || out_data !== dv(6, 0)) begin
         fails++; $display("FAIL dup_push: got err %b data %h want 1 %h", err, out_data, dv(6, 0));
      end
      out_ready = 1'b1;
      wait_done();
      tests++; if (done_cnt != 1 || outq.size() != 1 || outq[0] !== dv(6, 0)) begin
         fails++; $display("FAIL restart_done: got done %0d outs %0d data %h want 1 1 %h", done_cnt, outq.size(), outq[0], dv(6, 0));
      end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_reorder();
      test_window();
      test_backpressure();
      test_zero_len();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
